// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared PCSrc encodings, bubble instruction and fetch state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  // sll $0,$0,0 doubles as the pipeline bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/program_counter_reg.sv
// ============================================================================
// Module : program_counter_reg
// Brief  : Enable-gated PC register, async active-high reset to RESET_PC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module program_counter_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : PC, next-PC select, range/alignment halt and IF/ID register.
//          Optional macro FETCH_ALIGN_CHECK_EN halts on a misaligned target.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic [1:0]            PCSrc,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic [25:0]           JumpIndex,
  input  logic [DATA_WIDTH-1:0] JumpRegister,
  output logic [DATA_WIDTH-1:0] InstrAddress,
  input  logic [DATA_WIDTH-1:0] InstrIn,
  output logic [DATA_WIDTH-1:0] IFID_Instruction,
  output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic                  Halted,
  output logic [DATA_WIDTH-1:0] FetchCount
);

  // One extra bit so the window end cannot wrap when RESET_PC is high
  localparam logic [DATA_WIDTH:0] WINDOW_LO = {1'b0, RESET_PC};
  localparam logic [DATA_WIDTH:0] WINDOW_HI = WINDOW_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] next_pc_raw;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  misaligned;
  logic                  in_range;
  logic                  pc_en;

  assign pc_plus4     = pc + DATA_WIDTH'(4);
  assign InstrAddress = pc;
  assign Halted       = (state == HALT);
  assign in_range     = ({1'b0, pc} >= WINDOW_LO) && ({1'b0, pc} < WINDOW_HI);

  always_comb begin
    next_pc_raw = pc_plus4;
    case (PCSrc)
      PCSRC_SEQ:    next_pc_raw = pc_plus4;
      PCSRC_BRANCH: next_pc_raw = BranchTarget;
      PCSRC_JUMP:   next_pc_raw = {pc_plus4[DATA_WIDTH-1:28], JumpIndex, 2'b00};
      PCSRC_JR:     next_pc_raw = JumpRegister;
      default:      next_pc_raw = pc_plus4;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |next_pc_raw[1:0];
  assign next_pc    = next_pc_raw;
`else
  assign misaligned = 1'b0;
  assign next_pc    = next_pc_raw & ~DATA_WIDTH'(3);
`endif

  assign pc_en = (state == RUN) && !Stall && in_range && !misaligned;

  program_counter_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (next_pc),
    .q     (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RUN;
      IFID_Instruction <= '0;
      IFID_PCPlus4     <= '0;
      IFID_Valid       <= 1'b0;
      FetchCount       <= '0;
    end else begin
      case (state)
        RUN: begin
          if (Stall) begin
            // Flush still wins over Stall on the IF/ID register
            if (Flush) begin
              IFID_Instruction <= DATA_WIDTH'(NOP_INSTR);
              IFID_PCPlus4     <= '0;
              IFID_Valid       <= 1'b0;
            end
          end else if (!in_range || misaligned) begin
            state            <= HALT;
            IFID_Instruction <= DATA_WIDTH'(NOP_INSTR);
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
          end else if (Flush) begin
            IFID_Instruction <= DATA_WIDTH'(NOP_INSTR);
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
          end else begin
            IFID_Instruction <= InstrIn;
            IFID_PCPlus4     <= pc_plus4;
            IFID_Valid       <= 1'b1;
            if (FetchCount != '1) begin
              FetchCount <= FetchCount + DATA_WIDTH'(1);
            end
          end
        end
        HALT: begin
          IFID_Instruction <= DATA_WIDTH'(NOP_INSTR);
          IFID_PCPlus4     <= '0;
          IFID_Valid       <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module : tb_instruction_fetch_unit
// Brief  : Directed self-checking bench for instruction_fetch_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Flush;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [25:0] JumpIndex;
  logic [31:0] JumpRegister;
  logic [31:0] InstrAddress;
  logic [31:0] InstrIn;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        Halted;
  logic [31:0] FetchCount;

  logic [31:0] rom [0:31];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Combinational ROM; poison value outside the window
  assign InstrIn = (InstrAddress < 32'h80) ? rom[InstrAddress[6:2]] : 32'hDEAD_BEEF;

  instruction_fetch_unit #(
    .DATA_WIDTH   (32),
    .MEMORY_DEPTH (32),
    .RESET_PC     (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .PCSrc            (PCSrc),
    .BranchTarget     (BranchTarget),
    .JumpIndex        (JumpIndex),
    .JumpRegister     (JumpRegister),
    .InstrAddress     (InstrAddress),
    .InstrIn          (InstrIn),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .Halted           (Halted),
    .FetchCount       (FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge, so the pulse ends well before the next edge
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + i;
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0003;
    rom[2] = 32'h0109_5020;
    rom[3] = 32'h0000_0000;

    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; PCSrc = 2'b00;
    BranchTarget = 32'h0; JumpIndex = 26'h0; JumpRegister = 32'h0;
    #2;
    chk("rst_addr",  InstrAddress,     32'h0);
    chk("rst_instr", IFID_Instruction, 32'h0);
    chk("rst_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("rst_halt",  {31'b0, Halted},  32'h0);
    chk("rst_count", FetchCount,       32'h0);
    reset = 1'b0;

    // Sequential fetch
    step();
    chk("seq1_instr", IFID_Instruction, 32'h2008_0005);
    chk("seq1_pc4",   IFID_PCPlus4,     32'h4);
    chk("seq1_valid", {31'b0, IFID_Valid}, 32'h1);
    chk("seq1_addr",  InstrAddress,     32'h4);
    step();
    chk("seq2_instr", IFID_Instruction, 32'h2009_0003);
    chk("seq2_addr",  InstrAddress,     32'h8);
    step();
    chk("seq3_instr", IFID_Instruction, 32'h0109_5020);
    chk("seq3_addr",  InstrAddress,     32'hC);
    step();
    chk("seq4_instr", IFID_Instruction, 32'h0000_0000);
    chk("seq4_valid", {31'b0, IFID_Valid}, 32'h1);
    chk("seq4_pc4",   IFID_PCPlus4,     32'h10);
    chk("seq4_count", FetchCount,       32'h4);

    // Stall three cycles at PC=8, flush in the second
    pulse_reset();
    step(); step();
    chk("pre_stall_addr", InstrAddress, 32'h8);
    Stall = 1'b1; PCSrc = 2'b10; JumpIndex = 26'h10;
    step();
    chk("stall1_addr",  InstrAddress,     32'h8);
    chk("stall1_instr", IFID_Instruction, 32'h2009_0003);
    chk("stall1_count", FetchCount,       32'h2);
    Flush = 1'b1;
    step();
    chk("stall2_addr",  InstrAddress,     32'h8);
    chk("stall2_instr", IFID_Instruction, 32'h0);
    chk("stall2_valid", {31'b0, IFID_Valid}, 32'h0);
    Flush = 1'b0;
    step();
    chk("stall3_addr",  InstrAddress,     32'h8);
    chk("stall3_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("stall3_count", FetchCount,       32'h2);
    Stall = 1'b0; PCSrc = 2'b00;
    step();
    chk("unstall_instr", IFID_Instruction, 32'h0109_5020);
    chk("unstall_addr",  InstrAddress,     32'hC);
    chk("unstall_count", FetchCount,       32'h3);

    // Jump with flush at PC=4
    pulse_reset();
    step();
    PCSrc = 2'b10; JumpIndex = 26'h000_0002; Flush = 1'b1;
    step();
    chk("jmp_addr",  InstrAddress,     32'h8);
    chk("jmp_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("jmp_instr", IFID_Instruction, 32'h0);
    PCSrc = 2'b00; Flush = 1'b0;
    step();
    chk("jmp_next_instr", IFID_Instruction, 32'h0109_5020);
    chk("jmp_next_pc4",   IFID_PCPlus4,     32'hC);
    chk("jmp_next_count", FetchCount,       32'h2);

    // Branch redirect without flush still latches the redirect-cycle word
    PCSrc = 2'b01; BranchTarget = 32'h40;
    step();
    chk("br_addr",  InstrAddress,     32'h40);
    chk("br_instr", IFID_Instruction, 32'h0000_0000);
    chk("br_pc4",   IFID_PCPlus4,     32'h10);
    PCSrc = 2'b00;
    step();
    chk("br_next_instr", IFID_Instruction, 32'hA000_0010);

    // jr out of range, stalled first, then halt
    pulse_reset();
    PCSrc = 2'b11; JumpRegister = 32'h80;
    step();
    chk("jr_addr", InstrAddress, 32'h80);
    Stall = 1'b1; PCSrc = 2'b00;
    step();
    chk("oor_stall_halt",  {31'b0, Halted}, 32'h0);
    chk("oor_stall_instr", IFID_Instruction, 32'h2008_0005);
    Stall = 1'b0;
    step();
    chk("halt_flag",  {31'b0, Halted},     32'h1);
    chk("halt_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("halt_instr", IFID_Instruction,    32'h0);
    chk("halt_addr",  InstrAddress,        32'h80);
    chk("halt_count", FetchCount,          32'h1);
    for (int i = 0; i < 5; i++) begin
      PCSrc = 2'(i); Stall = i[0]; Flush = i[1]; BranchTarget = 32'h10; JumpRegister = 32'h8;
      step();
      chk("halt_hold_addr", InstrAddress, 32'h80);
      chk("halt_hold_flag", {31'b0, Halted}, 32'h1);
    end
    Stall = 1'b0; Flush = 1'b0; PCSrc = 2'b00;

    // Async reset while halted, mid-cycle
    #3;
    reset = 1'b1;
    #1;
    chk("arst_addr",  InstrAddress,        32'h0);
    chk("arst_halt",  {31'b0, Halted},     32'h0);
    chk("arst_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("arst_count", FetchCount,          32'h0);
    reset = 1'b0;
    step();
    chk("resume_instr", IFID_Instruction, 32'h2008_0005);
    chk("resume_addr",  InstrAddress,     32'h4);

    // Misaligned jr target
    pulse_reset();
    PCSrc = 2'b11; JumpRegister = 32'h6;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_halt",  {31'b0, Halted},     32'h1);
    chk("align_addr",  InstrAddress,        32'h0);
    chk("align_valid", {31'b0, IFID_Valid}, 32'h0);
`else
    chk("align_halt",  {31'b0, Halted},  32'h0);
    chk("align_addr",  InstrAddress,     32'h4);
    chk("align_instr", IFID_Instruction, 32'h2008_0005);
    PCSrc = 2'b00;
    step();
    chk("align_next_instr", IFID_Instruction, 32'h2009_0003);
    chk("align_next_addr",  InstrAddress,     32'h8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
